// File: rtl/key_pkg.sv
// Shared constants for the keypad conditioning path.
//   NUM_KEYS      : number of independent key channels
//   KEY_IDX_*     : bit position of each key on the key_* buses
//   key_can_repeat: which channels may auto-repeat (only meaningful with KEY_AUTOREPEAT_EN)
package key_pkg;

    localparam int unsigned NUM_KEYS     = 3;
    localparam int unsigned KEY_IDX_0    = 0;
    localparam int unsigned KEY_IDX_8    = 1;
    localparam int unsigned KEY_IDX_STAR = 2;

    // Navigation keys repeat when held; the star key is a one-shot command.
    function automatic bit key_can_repeat(input int unsigned idx);
        return (idx == KEY_IDX_0) || (idx == KEY_IDX_8);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One key channel: two-flop synchronizer, debounce counter, registered
// level plus one-cycle press/release pulses, optional auto-repeat.
// Optional feature macro: KEY_AUTOREPEAT_EN (adds REPEAT_* params and repeat logic).
// Ports:
//   clk       : system clock, rising edge
//   rst       : asynchronous active-high reset
//   i_raw     : raw key line, 1 = pressed
//   o_level   : debounced key level
//   o_press   : one-cycle pulse on accepted press (and on each repeat)
//   o_release : one-cycle pulse on accepted release
module key_debounce #(
    parameter int unsigned DEB_CNT       = 10000
`ifdef KEY_AUTOREPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY  = 500000,
    parameter int unsigned REPEAT_PERIOD = 100000,
    parameter bit          REPEAT_ALLOW  = 1'b1
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam int unsigned CNT_W = $clog2(DEB_CNT + 1);

    logic             r_s1;
    logic             r_s2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;
    logic             r_release;

    logic w_accept;
    logic w_rise;
    logic w_fall;
    logic w_rep_pulse;

    // The new level is taken on the DEB_CNT-th consecutive disagreeing cycle.
    assign w_accept = (r_s2 != r_stable) && (r_cnt == CNT_W'(DEB_CNT - 1));
    assign w_rise   = w_accept &  r_s2;
    assign w_fall   = w_accept & ~r_s2;

    // Synchronizer, debounce counter and edge pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_stable  <= 1'b0;
            r_cnt     <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_s1      <= i_raw;
            r_s2      <= r_s1;
            r_press   <= w_rise | w_rep_pulse;
            r_release <= w_fall;
            if (r_s2 == r_stable) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_stable <= r_s2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

`ifdef KEY_AUTOREPEAT_EN
    if (REPEAT_ALLOW) begin : g_repeat
        localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
        localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

        logic [REP_W-1:0] r_rep_cnt;
        logic             r_rep_first;
        logic [REP_W-1:0] w_rep_lim;
        logic             w_rep_hit;

        // First interval is the initial delay, later intervals the period.
        assign w_rep_lim   = r_rep_first ? REP_W'(REPEAT_DELAY) : REP_W'(REPEAT_PERIOD);
        // A release accepted this cycle wins over a repeat.
        assign w_rep_hit   = r_stable && !w_accept && ((r_rep_cnt + REP_W'(1)) == w_rep_lim);
        assign w_rep_pulse = w_rep_hit;

        // Counter measures cycles since the last press pulse while held.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_rep_cnt   <= '0;
                r_rep_first <= 1'b1;
            end else if (!r_stable || w_accept) begin
                r_rep_cnt   <= '0;
                r_rep_first <= 1'b1;
            end else if (w_rep_hit) begin
                r_rep_cnt   <= '0;
                r_rep_first <= 1'b0;
            end else begin
                r_rep_cnt <= r_rep_cnt + REP_W'(1);
            end
        end
    end else begin : g_no_repeat
        assign w_rep_pulse = 1'b0;
    end
`else
    assign w_rep_pulse = 1'b0;
`endif

    assign o_level   = r_stable;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule

// File: rtl/key_conditioner.sv
// Keypad input conditioning for the avoid-it game: three independent
// synchronize/debounce/edge-detect channels (key 0, key 8, key *).
// Optional feature macro: KEY_AUTOREPEAT_EN (auto-repeat on key 0 and key 8).
// Ports:
//   clk         : system clock, rising edge
//   rst         : asynchronous active-high reset
//   key_raw     : raw key lines, bit0 = key 0, bit1 = key 8, bit2 = key *
//   key_level   : debounced key levels
//   key_press   : one-cycle press pulses (plus repeats when enabled)
//   key_release : one-cycle release pulses
module key_conditioner
    import key_pkg::*;
#(
    parameter int unsigned DEB_CNT       = 10000,
    parameter int unsigned REPEAT_DELAY  = 500000,
    parameter int unsigned REPEAT_PERIOD = 100000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release
);

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        key_debounce #(
            .DEB_CNT       (DEB_CNT)
`ifdef KEY_AUTOREPEAT_EN
            ,
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD),
            .REPEAT_ALLOW  (key_can_repeat(int unsigned'(g)))
`endif
        ) u_deb (
            .clk       (clk),
            .rst       (rst),
            .i_raw     (key_raw[g]),
            .o_level   (key_level[g]),
            .o_press   (key_press[g]),
            .o_release (key_release[g])
        );
    end

    // Configuration sanity; repeat settings are checked even when unused.
    a_cfg_ok: assert property (@(posedge clk) disable iff (rst)
        (DEB_CNT >= 1) && (REPEAT_DELAY >= 1) && (REPEAT_PERIOD >= 1));

endmodule

// File: tb/tb_key_conditioner.sv
module tb_key_conditioner;

    localparam int unsigned DEB  = 4;
    localparam int unsigned RDLY = 10;
    localparam int unsigned RPER = 3;
    localparam int unsigned NK   = 3;
`ifdef KEY_AUTOREPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    typedef struct {
        logic [NK-1:0] lvl;
        logic [NK-1:0] prs;
        logic [NK-1:0] rel;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NK-1:0] key_raw = '1;
    logic [NK-1:0] key_level;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned n_press_seen = 0;

    exp_t exp_q[$];

    key_conditioner #(
        .DEB_CNT       (DEB),
        .REPEAT_DELAY  (RDLY),
        .REPEAT_PERIOD (RPER)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_raw     (key_raw),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release)
    );

    always #5 clk = ~clk;

    // Reference model: a key's accepted level flips when the DEB most recent
    // synchronized samples (raw samples two edges old and older) all agree on
    // the opposite value. Repeats are counted in edges since the press pulse.
    bit [DEB+1:0] hist [NK];
    bit           stbl [NK];
    int unsigned  rise_n [NK];
    int unsigned  edge_n = 0;

    always @(posedge clk) begin
        exp_t e;
        e.lvl = '0; e.prs = '0; e.rel = '0;
        if (rst) begin
            for (int k = 0; k < NK; k++) begin
                hist[k] = '0;
                stbl[k] = 1'b0;
                rise_n[k] = 0;
            end
        end else begin
            edge_n++;
            for (int k = 0; k < NK; k++) begin
                bit [DEB-1:0] win;
                hist[k] = {hist[k][DEB:0], key_raw[k]};
                win = hist[k][DEB+1:2];
                if (!stbl[k] && win == {DEB{1'b1}}) begin
                    stbl[k]   = 1'b1;
                    e.prs[k]  = 1'b1;
                    rise_n[k] = edge_n;
                end else if (stbl[k] && win == '0) begin
                    stbl[k]  = 1'b0;
                    e.rel[k] = 1'b1;
                end else if (REP_EN && k != 2 && stbl[k]) begin
                    int unsigned held;
                    held = edge_n - rise_n[k];
                    if (held >= RDLY && ((held - RDLY) % RPER) == 0) e.prs[k] = 1'b1;
                end
                e.lvl[k] = stbl[k];
            end
        end
        exp_q.push_back(e);
    end

    task automatic check3(input string name, input logic [NK-1:0] act, input logic [NK-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
        end
    endtask

    // Monitor: one expected entry per clock edge, compared just after the edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
        end else begin
            e = exp_q.pop_front();
            check3("key_level",   key_level,   e.lvl);
            check3("key_press",   key_press,   e.prs);
            check3("key_release", key_release, e.rel);
            n_press_seen += $countones(key_press);
        end
    end

    task automatic cycles(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // Reset is applied at the falling edge; outputs must clear immediately.
    task automatic pulse_reset(input int unsigned n);
        rst = 1'b1;
        #1;
        check3("reset_level",   key_level,   '0);
        check3("reset_press",   key_press,   '0);
        check3("reset_release", key_release, '0);
        cycles(n);
        rst = 1'b0;
    endtask

    initial begin
        int unsigned remain [NK];
        bit [NK-1:0] tmp;

        // Reset with all keys held, then release reset while still held.
        cycles(3);
        check3("reset_level",   key_level,   '0);
        check3("reset_press",   key_press,   '0);
        check3("reset_release", key_release, '0);
        rst = 1'b0;
        cycles(14);
        key_raw = '0;
        cycles(12);

        // Clean press/release on key 0.
        key_raw = 3'b001;
        cycles(20);
        key_raw = 3'b000;
        cycles(12);

        // Bounce on key 8, then steady hold.
        tmp = 5'b01101;
        for (int i = 0; i < 5; i++) begin
            key_raw[1] = tmp[i];
            cycles(1);
        end
        key_raw[1] = 1'b1;
        cycles(12);
        key_raw = 3'b000;
        cycles(12);

        // Simultaneous press, held long enough to exercise repeat.
        key_raw = 3'b111;
        cycles(DEB + 2 + 30);
        key_raw = 3'b000;
        cycles(12);

        // Reset while a debounce count is in progress.
        key_raw = 3'b001;
        cycles(4);
        pulse_reset(2);
        cycles(12);
        key_raw = 3'b000;
        cycles(12);

        // Randomized key activity mixing short bounces and long holds.
        for (int k = 0; k < NK; k++) remain[k] = 0;
        for (int c = 0; c < 2500; c++) begin
            for (int k = 0; k < NK; k++) begin
                if (remain[k] == 0) begin
                    key_raw[k] = ~key_raw[k];
                    remain[k] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, DEB + 1)
                                                             : $urandom_range(DEB, 30);
                end else begin
                    remain[k]--;
                end
            end
            if ($urandom_range(0, 399) == 0) pulse_reset($urandom_range(1, 3));
            else cycles(1);
        end
        key_raw = '0;
        cycles(20);

        n_checks++;
        if (n_press_seen == 0) begin
            n_fail++;
            $display("FAIL press_activity: got %0d press pulses expected at least 1", n_press_seen);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
